// File: rtl/socket_pkg.sv
// socket_pkg
//   Definitions shared by the socket-side blocks of the socket-to-module link:
//   default word width, the occupancy-width helper and the error-flag record
//   so sibling socket blocks report errors identically.
package socket_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than an index.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic ovf;
        logic unf;
    } socket_err_t;

endpackage

// File: rtl/socket_fifo_mem.sv
// socket_fifo_mem
//   DEPTH x DATA_WIDTH storage array: synchronous write port, combinational
//   read port. Contents are never reset.
//   Ports:
//     clk      - write clock (rising edge)
//     wr_en    - write strobe
//     wr_addr  - write index
//     wr_data  - write word
//     rd_addr  - read index
//     rd_data  - word at rd_addr (combinational)
module socket_fifo_mem
    import socket_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/socket_tx_fifo.sv
// socket_tx_fifo
//   Socket-side producer: a host pushes words through a write port, they are
//   buffered in a first-word-fall-through FIFO and presented to the module as
//   data/dv/full; the module pops with rd_en.
//   Ports:
//     clk      - single clock, rising edge
//     rst      - asynchronous, active-low reset
//     wr_en    - host push request
//     wr_data  - host push word
//     wr_full  - host backpressure (same as full)
//     data     - head-of-FIFO word, 0 while empty
//     dv       - FIFO non-empty
//     full     - FIFO holds DEPTH words
//     rd_en    - module pop request
//     level    - occupancy 0..DEPTH
//     ovf_err  - sticky: push refused because full and no pop
//     unf_err  - sticky: rd_en while empty
module socket_tx_fifo
    import socket_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_full,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          dv,
    output logic                          full,
    input  logic                          rd_en,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          ovf_err,
    output logic                          unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    socket_err_t           err_q;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // Flags decode from the registered level only.
    assign dv   = (level_q != '0);
    assign full = (level_q == LW'(DEPTH));

    // A push into a full FIFO is only taken when a pop frees a slot this cycle.
    assign pop  = rd_en & dv;
    assign push = wr_en & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            err_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
            if (wr_en && !push) begin
                err_q.ovf <= 1'b1;
            end
            if (rd_en && !dv) begin
                err_q.unf <= 1'b1;
            end
        end
    end

    socket_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Array is not reset, so mask stale contents whenever the FIFO is empty.
    assign data    = dv ? head : '0;
    assign wr_full = full;
    assign level   = level_q;
    assign ovf_err = err_q.ovf;
    assign unf_err = err_q.unf;

endmodule

// File: tb/tb_socket_tx_fifo.sv
// tb_socket_tx_fifo
//   Self-checking bench for socket_tx_fifo: a hand-computed vector table,
//   directed multi-cycle sequences and random traffic against a queue model.
module tb_socket_tx_fifo;
    import socket_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = level_width(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          wr_full;
    logic [DW-1:0] data;
    logic          dv;
    logic          full;
    logic [LW-1:0] level;
    logic          ovf_err;
    logic          unf_err;

    always #5 clk = ~clk;

    socket_tx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_full (wr_full),
        .data    (data),
        .dv      (dv),
        .full    (full),
        .rd_en   (rd_en),
        .level   (level),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of buffered words plus the two sticky flags.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_unf;

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          dv;
        logic [DW-1:0] data;
        logic [LW-1:0] level;
        logic          full;
        logic          ovf;
        logic          unf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [DW-1:0] wd, input logic re);
        bit has;
        bit is_full;
        bit do_pop;
        bit do_push;
        has     = (mq.size() != 0);
        is_full = (mq.size() == DEPTH);
        do_pop  = re && has;
        do_push = we && (!is_full || do_pop);
        if (re && !has) m_unf = 1'b1;
        if (we && !do_push) m_ovf = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(wd);
    endtask

    task automatic chk_model(input string tag);
        logic [DW-1:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".dv"},      32'(dv),      32'(mq.size() != 0));
        chk({tag, ".data"},    32'(data),    32'(exp_data));
        chk({tag, ".level"},   32'(level),   32'(mq.size()));
        chk({tag, ".full"},    32'(full),    32'(mq.size() == DEPTH));
        chk({tag, ".wr_full"}, 32'(wr_full), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"},     32'(ovf_err), 32'(m_ovf));
        chk({tag, ".unf"},     32'(unf_err), 32'(m_unf));
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        model_step(we, wd, re);
        #1;
    endtask

    // Three cycles of reset with a push pending, released between edges.
    task automatic do_reset();
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        rd_en   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic fill_seq();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            chk_model("fill");
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   max_level;

        // Reset state
        do_reset();
        chk("reset.dv",    32'(dv),      0);
        chk("reset.full",  32'(full),    0);
        chk("reset.wfull", 32'(wr_full), 0);
        chk("reset.level", 32'(level),   0);
        chk("reset.data",  32'(data),    0);
        chk("reset.ovf",   32'(ovf_err), 0);
        chk("reset.unf",   32'(unf_err), 0);

        // Hand-computed vectors from empty:   we  wd     re  dv  data   lvl  full ovf unf
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'hB2, 1'b0, 1'b1, 8'hA1, 5'd2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 8'hD4, 1'b1, 1'b1, 8'hD4, 5'd1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hD4, 5'd1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].re);
            chk("tbl.dv",    32'(dv),      32'(tbl[i].dv));
            chk("tbl.data",  32'(data),    32'(tbl[i].data));
            chk("tbl.level", 32'(level),   32'(tbl[i].level));
            chk("tbl.full",  32'(full),    32'(tbl[i].full));
            chk("tbl.ovf",   32'(ovf_err), 32'(tbl[i].ovf));
            chk("tbl.unf",   32'(unf_err), 32'(tbl[i].unf));
        end

        // Fill, overflow, drain, underflow
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        chk("fill.first_dv",   32'(dv),   1);
        chk("fill.first_data", 32'(data), 32'h01);
        for (int i = 2; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            chk_model("fill");
        end
        chk("fill.full",  32'(full),  1);
        chk("fill.level", 32'(level), 16);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf.flag",  32'(ovf_err), 1);
        chk("ovf.level", 32'(level),   16);
        chk("ovf.head",  32'(data),    32'h01);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain.data", 32'(data), 32'(i));
            step(1'b0, 8'h00, 1'b1);
            chk_model("drain");
            if (i == 1) chk("drain.full_fall", 32'(full), 0);
        end
        chk("drain.dv_low", 32'(dv), 0);
        chk("drain.unf_before", 32'(unf_err), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("unf.flag", 32'(unf_err), 1);

        // Simultaneous push/pop while full
        do_reset();
        fill_seq();
        step(1'b1, 8'h55, 1'b1);
        chk("fullpp.level", 32'(level),   16);
        chk("fullpp.ovf",   32'(ovf_err), 0);
        chk("fullpp.full",  32'(full),    1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("fullpp.data", 32'(data), (i == DEPTH) ? 32'h55 : 32'(i + 1));
            step(1'b0, 8'h00, 1'b1);
            chk_model("fullpp");
        end

        // Wrap-around streaming: 40 words, pop every cycle after the first push
        do_reset();
        max_level = 0;
        step(1'b1, 8'h00, 1'b0);
        chk("stream.first", 32'(data), 0);
        for (int i = 1; i < 40; i++) begin
            step(1'b1, DW'(i), 1'b1);
            chk("stream.data", 32'(data), 32'(i));
            chk_model("stream");
            if (int'(level) > max_level) max_level = int'(level);
        end
        step(1'b0, 8'h00, 1'b1);
        chk_model("stream.end");
        chk("stream.max_level", 32'(max_level), 1);
        chk("stream.ovf", 32'(ovf_err), 0);
        chk("stream.unf", 32'(unf_err), 0);

        // Asynchronous reset between edges at level 7
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h70 + i), 1'b0);
        chk("midrst.level_pre", 32'(level), 7);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.dv",    32'(dv),    0);
        chk("midrst.level", 32'(level), 0);
        chk("midrst.data",  32'(data),  0);
        #1;
        rst = 1'b1;
        model_reset();
        step(1'b1, 8'h3C, 1'b0);
        chk("midrst.next_word", 32'(data), 32'h3C);
        chk_model("midrst");

        // Random traffic in push-heavy / pop-heavy phases
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int wpct;
            int rpct;
            logic we;
            logic re;
            wpct = ((i / 100) % 2 == 0) ? 80 : 30;
            rpct = ((i / 100) % 2 == 0) ? 30 : 80;
            we = ($urandom_range(0, 99) < wpct);
            re = ($urandom_range(0, 99) < rpct);
            step(we, DW'($urandom), re);
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/socket_tx_fifo.md
# socket_tx_fifo

Socket-side producer for the socket-to-module link. A host or testbench pushes words through a simple write port. The block buffers them in a DEPTH-entry synchronous FIFO and presents them to a processing module as data/dv/full. The module consumes words by asserting rd_en. This is the transmitting end for any module that reads through the socket-to-module interface.

## Interface
- DATA_WIDTH, 8, word width; must match the module's interface DATA_WIDTH
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  host push request
- wr_data  in  DATA_WIDTH  host push word
- wr_full  out  1  host backpressure; identical to full
- data  out  DATA_WIDTH  head-of-FIFO word to module
- dv  out  1  data valid; FIFO non-empty
- full  out  1  FIFO holds DEPTH words
- rd_en  in  1  module pop request
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- ovf_err  out  1  sticky: push attempted while full and not popped
- unf_err  out  1  sticky: rd_en asserted while dv=0

## Operation
- Storage: DEPTH-word array, wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH. The level counter is kept separately.
- The FIFO is first-word-fall-through: data = mem[rd_ptr] while dv=1, forced to 0 while dv=0.
- dv = (level != 0); full = (level == DEPTH); both are decoded from registered level.
- pop = rd_en & dv. rd_en with dv=0 is ignored and sets unf_err.
- push = wr_en & (!full | pop). A push while full is accepted only when a pop happens in the same cycle. Otherwise the word is dropped, ovf_err is set, and state is unchanged.
- Level update: push & !pop gives +1; pop & !push gives −1; otherwise unchanged.
- Empty with wr_en=1 and rd_en=1: the push is accepted, the pop is ignored, unf_err is set, and level becomes 1.
- ovf_err and unf_err clear only on reset.
- rst low, asynchronous: level=0, pointers=0, dv=0, full=0, wr_full=0, data=0, ovf_err=0, unf_err=0.
- Array contents are not reset.
- Reset mid-transfer discards all buffered words.

## Timing
- Push at edge t: the word is visible on data with dv=1 after edge t, provided the FIFO was empty. Write-to-dv latency is 1 cycle.
- Pop at edge t: the next word, or dv=0, appears after edge t. The module may hold rd_en high for back-to-back pops at 1 word/cycle.
- full and wr_full rise in the cycle after the DEPTH-th net push. They fall in the cycle after the first pop.
- Sustained streaming at 1 word/cycle with simultaneous push and pop is supported at any occupancy 1..DEPTH.
- Reset deassertion: the first push is accepted on the first rising edge with rst=1.

## Structure
- Package socket_pkg holds:
  - a constant for the default DATA_WIDTH;
  - the function clog2-based width helper for level;
  - an error-flag struct typedef {ovf, unf}, so sibling socket blocks report errors identically.
- One sub-module, socket_fifo_mem: DEPTH×DATA_WIDTH array with a synchronous write port and a combinational read port. It holds no reset logic.
- Pointers, level, flags and the output gating live in socket_tx_fifo.

## Test plan
- Reset: hold rst=0 for 3 cycles with wr_en=1 -> after release dv=0, full=0, level=0, data=0, both errors 0, and nothing stored.
- Fill: push 0x01..0x10 on consecutive cycles with rd_en=0 -> dv=1 one cycle after the first push with data=0x01; full=1 and level=16 after the 16th push. A 17th push of 0xAA is dropped, ovf_err=1, level stays 16.
- Drain, then underflow:
  - hold rd_en=1 from the full state -> data reads 0x01..0x10 on consecutive cycles, full falls after the first pop, and dv=0 after the 16th pop;
  - keep rd_en=1 one more cycle -> unf_err=1.
- Full with simultaneous push/pop: at level=16, wr_en=1 with 0x55 and rd_en=1 in the same cycle -> pop accepted, push accepted, level stays 16, ovf_err stays 0. 0x55 emerges as the 16th word after that pop.
- Wrap-around streaming:
  - push 40 sequential words 0x00..0x27 with rd_en=1 continuously after the first word -> the output sequence is identical and gap-free;
  - level never exceeds 1 and pointers wrap twice without error.
- Reset mid-operation: at level=7, pull rst low asynchronously between edges -> dv, level and data go to 0 immediately. After release, a push of 0x3C is the next word read.
